// File: rtl/elevator_pkg.sv
// Shared types and helpers for the four-floor elevator scheduler.
//   - state_t      : sequencer states (IDLE, MOVE, DOOR)
//   - NUM_FLOORS   : number of served floors
//   - FLOOR_W      : floor index width
//   - above_mask / below_mask / floor_onehot : floor-vector helpers
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = 2;

  localparam logic [FLOOR_W-1:0] FLOOR_0 = 2'd0;
  localparam logic [FLOOR_W-1:0] FLOOR_1 = 2'd1;
  localparam logic [FLOOR_W-1:0] FLOOR_2 = 2'd2;
  localparam logic [FLOOR_W-1:0] FLOOR_3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  // Bit i set for every floor strictly above f.
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  // Bit i set for every floor strictly below f.
  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i == int'(f));
    return m;
  endfunction

endpackage

// File: rtl/elevator_scheduler_tick_timer.sv
// Cycle timer shared by the MOVE and DOOR phases.
// Counts 0..limit while enabled; done pulses on the cycle the count
// equals limit, and the count wraps back to 0 on that edge.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : force count to 0 (state entry / door restart)
//   enable     : count this cycle
//   limit      : terminal count (phase length minus one)
//   done       : terminal count reached this cycle
module tick_timer #(
  parameter int MAX = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [$clog2(MAX)-1:0]   limit,
  output logic                     done
);

  logic [$clog2(MAX)-1:0] count;

  assign done = enable & (count == limit);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// Collective-control scheduler for a four-floor elevator.
// Latches car buttons and hall calls, picks a travel direction and walks
// the car through MOVE / DOOR phases using one shared cycle timer.
//   clk, reset   : system clock, synchronous active-high reset
//   car_btn[3:0] : car buttons, bit i = floor i
//   hall_up[2:0] : up calls, bit i = floor i
//   hall_dn[2:0] : down calls, bit i = floor i+1
//   actual_floor : current floor
//   dir_up       : travel / preference direction (1 = up)
//   moving       : car in MOVE
//   door_open    : car in DOOR
//   car_pend, up_pend, dn_pend : pending request lamps
//
// state | meaning
// IDLE  | parked, door closed, choosing next direction
// MOVE  | travelling one floor per TRAVEL_CYCLES
// DOOR  | door open at actual_floor, requests there absorbed
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         car_btn,
  input  logic [2:0]         hall_up,
  input  logic [2:0]         hall_dn,
  output logic [FLOOR_W-1:0] actual_floor,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open,
  output logic [3:0]         car_pend,
  output logic [2:0]         up_pend,
  output logic [2:0]         dn_pend
);

  localparam int TMR_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] TRAVEL_LIM = TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [TMR_W-1:0] DOOR_LIM   = TMR_W'(DOOR_CYCLES - 1);

  state_t             state, state_nx;
  logic [FLOOR_W-1:0] floor_nx;
  logic               dir_nx;
  logic               tmr_clear, tmr_done;
  logic [TMR_W-1:0]   tmr_limit;
  logic               clear_here;

  // Per-floor views of the request registers and the live inputs.
  logic [NUM_FLOORS-1:0] up_all, dn_all, any_all, in_all, clr_mask;
  logic                  here_cur, above_cur, below_cur, press_here;
  logic [FLOOR_W-1:0]    nf;
  logic                  ahead_nf, dir_call_nf, stop_nf;

  assign up_all  = {1'b0, up_pend};
  assign dn_all  = {dn_pend, 1'b0};
  assign any_all = car_pend | up_all | dn_all;
  assign in_all  = car_btn | {1'b0, hall_up} | {hall_dn, 1'b0};

  assign here_cur   = any_all[actual_floor];
  assign above_cur  = |(any_all & above_mask(actual_floor));
  assign below_cur  = |(any_all & below_mask(actual_floor));
  assign press_here = in_all[actual_floor];

  // Arrival floor; only meaningful in MOVE, where a request ahead keeps it in range.
  assign nf          = dir_up ? actual_floor + 2'd1 : actual_floor - 2'd1;
  assign ahead_nf    = dir_up ? |(any_all & above_mask(nf)) : |(any_all & below_mask(nf));
  assign dir_call_nf = dir_up ? up_all[nf] : dn_all[nf];
  // Nothing further ahead also covers the end floors, so the car never overruns.
  assign stop_nf     = car_pend[nf] | dir_call_nf | ~ahead_nf;

  assign clr_mask  = clear_here ? floor_onehot(actual_floor) : '0;
  assign moving    = (state == MOVE);
  assign door_open = (state == DOOR);

  tick_timer #(.MAX(TMR_MAX)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (state != IDLE),
    .limit  (tmr_limit),
    .done   (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      actual_floor <= FLOOR_0;
      dir_up       <= 1'b1;
    end else begin
      state        <= state_nx;
      actual_floor <= floor_nx;
      dir_up       <= dir_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    floor_nx   = actual_floor;
    dir_nx     = dir_up;
    tmr_clear  = 1'b0;
    tmr_limit  = TRAVEL_LIM;
    clear_here = 1'b0;
    case (state)
      IDLE: begin
        if (here_cur) begin
          state_nx  = DOOR;
          tmr_clear = 1'b1;
        end else if (dir_up ? above_cur : below_cur) begin
          state_nx  = MOVE;
          tmr_clear = 1'b1;
        end else if (dir_up ? below_cur : above_cur) begin
          dir_nx    = ~dir_up;
          state_nx  = MOVE;
          tmr_clear = 1'b1;
        end
      end
      MOVE: begin
        if (tmr_done) begin
          floor_nx = nf;
          if (stop_nf) begin
            state_nx  = DOOR;
            tmr_clear = 1'b1;
          end
        end
      end
      DOOR: begin
        tmr_limit  = DOOR_LIM;
        clear_here = 1'b1;
        // A fresh press at this floor holds the door for a full period again.
        if (press_here) begin
          tmr_clear = 1'b1;
        end else if (tmr_done) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Clear wins over set so a press at the open-door floor never sticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      car_pend <= '0;
      up_pend  <= '0;
      dn_pend  <= '0;
    end else begin
      car_pend <= (car_pend | car_btn) & ~clr_mask;
      up_pend  <= (up_pend | hall_up)  & ~clr_mask[2:0];
      dn_pend  <= (dn_pend | hall_dn)  & ~clr_mask[3:1];
    end
  end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Collective-control scheduler for the four-floor elevator. Latches hall calls (up/down switches) and car buttons into pending-request registers, chooses direction, and sequences the car through move, stop and door phases with cycle-counted travel and door timers. Its floor, direction and stop/go outputs feed the display controller and floor indicators, replacing the ad-hoc comparator and memory chain with one owned sequencer.

## Interface
Parameters:
- TRAVEL_CYCLES, 50_000_000: clocks per one-floor move (≥2).
- DOOR_CYCLES, 100_000_000: clocks the door stays open (≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- car_btn  in  4  car floor buttons, bit i = floor i; level, held ≥1 clk.
- hall_up  in  3  up-call switches, bit i = floor i (floors 0–2).
- hall_dn  in  3  down-call switches, bit i = floor i+1 (floors 1–3).
- actual_floor  out  2  current car floor.
- dir_up  out  1  1 = travel/preference up.
- moving  out  1  1 in MOVE (go), 0 otherwise (stop).
- door_open  out  1  1 in DOOR.
- car_pend  out  4  pending car requests (lamps).
- up_pend  out  3  pending up calls.
- dn_pend  out  3  pending down calls.

## Operation
- Reset values: actual_floor=0, dir_up=1, moving=0, door_open=0, all pending=0, state IDLE, timer 0.
- Latching: every edge, pend <= (pend | input) & ~clear_mask. Clear wins over set in the same cycle.
- Definitions at floor f: here = car_pend[f] | up_pend[f] | dn_pend[f] (non-existent bits read 0); above = any pending at floor >f; below = any pending at floor <f.
- States IDLE, MOVE, DOOR.
- IDLE: if here → DOOR. Else if dir_up ? above : below → MOVE, keep dir. Else if opposite side pending → flip dir_up, MOVE. Else stay.
- MOVE: timer counts 0..TRAVEL_CYCLES-1; at terminal count floor steps ±1, timer→0. Stop at new floor nf if car_pend[nf], or call in travel direction at nf, or no request ahead of nf in travel direction (with any call at nf). Stop → DOOR; else continue MOVE.
- DOOR: clear_mask covers all requests at actual_floor every cycle (new presses at that floor absorbed). An input asserting at the current floor restarts door timer. After DOOR_CYCLES → IDLE. If no requests ahead in dir_up on exit, IDLE's reversal rule applies.
- Car never leaves 0..3: MOVE only entered with a request ahead, and arrival at 0 or 3 always stops (nothing ahead).
- reset mid-operation: all state returns to reset values on that edge; pending requests lost.

## Timing
- Input high at edge k → pend bit set visible after edge k.
- IDLE decision from registered pend: state changes one edge after pend set (2 edges from press).
- MOVE entry to floor change: exactly TRAVEL_CYCLES edges; stop decision and DOOR entry on the same edge as floor change.
- door_open high exactly DOOR_CYCLES cycles absent restarts.
- Outputs all registered; no combinational input→output path.

## Structure
- Package elevator_pkg: state enum (IDLE, MOVE, DOOR), NUM_FLOORS=4, FLOOR_W=2, floor constants.
- Sub-module tick_timer (parameter MAX, inputs clear/enable, output done): single instance shared by MOVE and DOOR, width $clog2 of max(TRAVEL_CYCLES, DOOR_CYCLES); cleared on each state entry.
- Remainder: pending registers, ahead/behind reduction logic, FSM.

## Test plan (TRAVEL_CYCLES=4, DOOR_CYCLES=8)
- Reset, then car_btn=4'b0100 one cycle → MOVE up; floor 1 after 4 cycles, floor 2 after 8, door_open 8 cycles, car_pend→0, back to IDLE at floor 2.
- At floor 0, hall_dn[2] (floor 3 down) and hall_up[1] → stops floor 1 (up call), then floor 3; floor 3 call cleared; dir_up stays 1 until reversal.
- At floor 0 moving up to 3, hall_dn[0] (floor 1 down) pressed → car passes floor 1 without stopping, serves 3, reverses, stops at 1.
- car_btn[actual_floor] pressed in IDLE → DOOR with no movement; pressed again mid-DOOR → timer restarts, door_open extends to 8 cycles from that press.
- Press during MOVE at same edge as floor arrival for that floor → serviced there, pend bit ends 0.
- Assert reset mid-MOVE → next cycle floor=0, moving=0, dir_up=1, all pending=0.
